// File: rtl/game_report_tx_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// game_report_tx_pkg : shared types, message tables and byte helpers for the
//                      UART game-event reporter.          Rev 1.0
// ----------------------------------------------------------------------------
package game_report_tx_pkg;

  typedef enum logic [3:0] {
    NONE, WAIT, LEFT, RIGHT, DOWN, DROP, HOLD, ROTATE, ROTATE_REV
  } state_type;

  typedef enum logic [1:0] {REP_CMD, REP_SCORE, REP_OVER} report_kind_t;

  typedef enum logic [2:0] {ST_IDLE, ST_POP, ST_SEND, ST_ARM, ST_DRAIN} report_fsm_t;

  typedef struct packed {
    report_kind_t kind;
    logic [15:0]  payload;
  } report_entry_t;

  localparam int SCORE_LEN = 7;
  localparam int OVER_LEN  = 11;

  localparam byte OVER_MSG [0:10] = '{
    8'h47, 8'h41, 8'h4D, 8'h45, 8'h20, 8'h4F, 8'h56, 8'h45, 8'h52, 8'h0D, 8'h0A
  };

  // Zero marks a command that is never reported.
  function automatic logic [7:0] cmd_char(state_type c);
    case (c)
      LEFT:       return 8'h61;
      RIGHT:      return 8'h64;
      DOWN:       return 8'h73;
      DROP:       return 8'h77;
      HOLD:       return 8'h63;
      ROTATE:     return 8'h78;
      ROTATE_REV: return 8'h7A;
      default:    return 8'h00;
    endcase
  endfunction

  function automatic logic cmd_reportable(state_type c);
    return cmd_char(c) != 8'h00;
  endfunction

  function automatic logic [7:0] hex_digit(logic [3:0] d);
    return (d < 4'd10) ? 8'h30 + {4'h0, d} : 8'h37 + {4'h0, d};
  endfunction

  function automatic logic [3:0] last_idx(report_kind_t k);
    case (k)
      REP_SCORE: return 4'(SCORE_LEN - 1);
      REP_OVER:  return 4'(OVER_LEN - 1);
      default:   return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] msg_byte(report_entry_t e, logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (e.kind)
      REP_CMD:   b = e.payload[7:0];
      REP_SCORE: begin
        case (idx)
          4'd0:    b = 8'h50;
          4'd1:    b = hex_digit(e.payload[15:12]);
          4'd2:    b = hex_digit(e.payload[11:8]);
          4'd3:    b = hex_digit(e.payload[7:4]);
          4'd4:    b = hex_digit(e.payload[3:0]);
          4'd5:    b = 8'h0D;
          4'd6:    b = 8'h0A;
          default: b = 8'h00;
        endcase
      end
      REP_OVER:  if (idx < 4'(OVER_LEN)) b = OVER_MSG[idx];
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_report_tx_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// game_report_tx_if : transmit handshake between the reporter and the uart.
//                     Rev 1.0
// ----------------------------------------------------------------------------
interface game_report_tx_if;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       tx_busy;

  modport master (output transmit, output tx_byte, input tx_busy);
  modport slave  (input transmit, input tx_byte, output tx_busy);
endinterface
`default_nettype wire

// File: rtl/game_report_tx_event_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// game_report_tx_event_fifo : DEPTH-entry event FIFO with head-of-queue output.
//                             Rev 1.0
// ----------------------------------------------------------------------------
module game_report_tx_event_fifo
  import game_report_tx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  report_entry_t wr_data,
  input  logic          rd_en,
  output report_entry_t rd_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  report_entry_t   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            wr_ok;
  logic            rd_ok;

  // A pop frees the slot the same cycle, so a full FIFO still takes a write.
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/game_report_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// game_report_tx : queues game events and serialises them as ASCII messages
//                  into the uart transmit handshake.      Rev 1.0
// ----------------------------------------------------------------------------
module game_report_tx
  import game_report_tx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  input  state_type               cmd,
  input  logic                    score_valid,
  input  logic [15:0]             score,
  input  logic                    game_over,
  game_report_tx_if.master        uart,
  output logic                    pending,
  output logic [7:0]              drop_cnt
);

  report_fsm_t   state;
  report_entry_t cur;
  logic [3:0]    idx;

  report_entry_t wr_entry;
  report_entry_t head;
  logic          wr_req;
  logic          rd_en;
  logic          full;
  logic          empty;
  logic          cmd_ok;
  logic [1:0]    collide;
  logic          overflow;
  logic [8:0]    drop_sum;

  assign cmd_ok = cmd_valid && cmd_reportable(cmd);

  always_comb begin
    wr_req           = 1'b0;
    wr_entry.kind    = REP_CMD;
    wr_entry.payload = 16'h0000;
    collide          = 2'd0;
    if (game_over) begin
      wr_req        = 1'b1;
      wr_entry.kind = REP_OVER;
      collide       = {1'b0, score_valid} + {1'b0, cmd_ok};
    end else if (score_valid) begin
      wr_req           = 1'b1;
      wr_entry.kind    = REP_SCORE;
      wr_entry.payload = score;
      collide          = {1'b0, cmd_ok};
    end else if (cmd_ok) begin
      wr_req           = 1'b1;
      wr_entry.payload = {8'h00, cmd_char(cmd)};
    end
  end

  assign rd_en    = (state == ST_POP);
  assign overflow = wr_req && full && !rd_en;
  assign drop_sum = {1'b0, drop_cnt} + 9'(collide) + 9'(overflow);
  assign pending  = !empty || (state != ST_IDLE);

  game_report_tx_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_req),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 8'd0;
    end else begin
      drop_cnt <= (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
    end
  end

  // transmit/tx_byte are loaded on entry to SEND so they are valid for exactly that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cur           <= '0;
      idx           <= 4'd0;
      uart.transmit <= 1'b0;
      uart.tx_byte  <= 8'h00;
    end else begin
      uart.transmit <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!empty) state <= ST_POP;
        end
        ST_POP: begin
          cur           <= head;
          idx           <= 4'd0;
          uart.transmit <= 1'b1;
          uart.tx_byte  <= msg_byte(head, 4'd0);
          state         <= ST_SEND;
        end
        ST_SEND: begin
          state <= ST_ARM;
        end
        ST_ARM: begin
          if (uart.tx_busy) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!uart.tx_busy) begin
            if (idx == last_idx(cur.kind)) begin
              state <= ST_IDLE;
            end else begin
              idx           <= idx + 4'd1;
              uart.transmit <= 1'b1;
              uart.tx_byte  <= msg_byte(cur, idx + 4'd1);
              state         <= ST_SEND;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
